mont_redc: RTL

//  Bit-serial Montgomery reduction: converts an operand out of the Montgomery domain.
//  red_out = (num_in * R^-1) mod modulus, with R = 2^len.

---
 rtl/mont_redc_if.sv | 37 +++
 rtl/mont_redc.sv | 102 ++++++++++
 2 files changed

// File: rtl/mont_redc_if.sv
// Start/done handshake bundle shared by the Montgomery domain converters.
// red_err only exists when MONT_REDC_ERR_EN is defined.
interface mont_redc_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             md_start;
  logic [7:0]       len;
  logic [WIDTH-1:0] num_in;
  logic [WIDTH-1:0] modulus;
  logic             md_end;
  logic [WIDTH-1:0] red_out;
`ifdef MONT_REDC_ERR_EN
  logic             red_err;

  modport master (
    output md_start, len, num_in, modulus,
    input  md_end, red_out, red_err
  );

  modport slave (
    input  md_start, len, num_in, modulus,
    output md_end, red_out, red_err
  );
`else
  modport master (
    output md_start, len, num_in, modulus,
    input  md_end, red_out
  );

  modport slave (
    input  md_start, len, num_in, modulus,
    output md_end, red_out
  );
`endif

endinterface

// File: rtl/mont_redc.sv
// Bit-serial Montgomery reduction: red_out = num_in * 2^-len mod modulus.
// Define MONT_REDC_ERR_EN to reject even moduli with red_err instead of computing.
module mont_redc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rstn,
  mont_redc_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   t_q;
  logic [WIDTH-1:0] n_q;
  logic [7:0]       iter_q;
`ifdef MONT_REDC_ERR_EN
  logic             err_q;
`endif

  logic [WIDTH:0] half_sum;
  logic [WIDTH:0] n_ext;
  logic           t_ge_n;

  // (t + n) >> 1 formed from the pre-shifted halves plus the dropped-LSB carry,
  // so the WIDTH+2-bit intermediate never needs to exist.
  always_comb begin
    half_sum = {1'b0, t_q[WIDTH:1]};
    if (t_q[0]) begin
      half_sum = {1'b0, t_q[WIDTH:1]} + {2'b00, n_q[WIDTH-1:1]}
               + {{WIDTH{1'b0}}, n_q[0]};
    end
  end

  assign n_ext  = {1'b0, n_q};
  assign t_ge_n = (t_q >= n_ext);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      t_q     <= '0;
      n_q     <= '0;
      iter_q  <= '0;
`ifdef MONT_REDC_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.md_start) begin
            t_q    <= {1'b0, bus.num_in};
            n_q    <= bus.modulus;
            iter_q <= bus.len;
`ifdef MONT_REDC_ERR_EN
            err_q  <= 1'b0;
            if (!bus.modulus[0]) begin
              t_q     <= '0;
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= (bus.len != 8'd0) ? StCalc : StFix;
            end
`else
            state_q <= (bus.len != 8'd0) ? StCalc : StFix;
`endif
          end
        end
        StCalc: begin
          t_q    <= half_sum;
          iter_q <= iter_q - 8'd1;
          if (iter_q == 8'd1) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (t_ge_n) begin
            t_q <= t_q - n_ext;
          end
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.md_end  = (state_q == StDone);
  assign bus.red_out = (state_q == StDone) ? t_q[WIDTH-1:0] : '0;
`ifdef MONT_REDC_ERR_EN
  assign bus.red_err = (state_q == StDone) & err_q;
`endif

endmodule
